// File: rtl/spi_pkg.sv
// Shared SPI definitions for the mode-0 master/slave pair.
// Holds the frame state encoding and the link-wide constants.
package spi_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } spi_state_t;

  localparam logic SPI_CPOL   = 1'b0;
  localparam logic SPI_CPHA   = 1'b0;
  localparam int   SPI_DATA_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detect
// against one extra registered copy of the synchronized value.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_d, sync_q;
  logic              prev_d, prev_q;

  // Shift the raw input down the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Chain and history flops; clearing to 0 makes a held-low cs_n look selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 (CPOL=0, CPHA=0) MSB-first SPI responder, oversampled on clk.
// Delivers received bytes on rx_valid and loads TX bytes via valid/ready.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                 DATA_W      = SPI_DATA_W,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  TX_IDLE     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              abort
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);

  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic cs_n_s, cs_rise_s, cs_fall_s;
  logic unused_mosi_edges_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_n_s), .rise(cs_rise_s), .fall(cs_fall_s)
  );

  assign unused_mosi_edges_s = mosi_rise_s ^ mosi_fall_s;

  spi_state_t        state_d, state_q;
  logic [CNT_W-1:0]  bit_cnt_d, bit_cnt_q, cnt_inc_s;
  logic [DATA_W-2:0] rx_shift_d, rx_shift_q;
  logic [DATA_W-2:0] tx_shift_d, tx_shift_q;
  logic [DATA_W-1:0] rx_data_d, rx_data_q, rx_next_s, tx_load_s;
  logic              rx_valid_d, rx_valid_q;
  logic              abort_d, abort_q;
  logic              byte_done_d, byte_done_q;
  logic              miso_d, miso_q;
  logic              busy_d, busy_q;
  logic              load_s;

  // Frame FSM, bit counter and both shift paths.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    abort_d     = 1'b0;
    byte_done_d = byte_done_q;
    miso_d      = miso_q;
    load_s      = 1'b0;
    cnt_inc_s   = bit_cnt_q + CNT_ONE;
    rx_next_s   = {rx_shift_q, mosi_s};
    tx_load_s   = tx_valid ? tx_data : TX_IDLE;

    case (state_q)
      RESYNC: begin
        miso_d = 1'b0;
        if (cs_n_s) begin
          state_d = IDLE;
        end else begin
          state_d = RESYNC;
        end
      end
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall_s) begin
          state_d     = ACTIVE;
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
          load_s      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (sclk_rise_s) begin
          rx_shift_d = rx_next_s[DATA_W-2:0];
          if (cnt_inc_s == CNT_FULL) begin
            rx_data_d   = rx_next_s;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            byte_done_d = 1'b1;
          end else begin
            bit_cnt_d = cnt_inc_s;
          end
        end else if (sclk_fall_s) begin
          if (byte_done_q) begin
            byte_done_d = 1'b0;
            load_s      = 1'b1;
          end else begin
            miso_d     = tx_shift_q[DATA_W-2];
            tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        // The sclk edge above is already folded into bit_cnt_d, so a byte
        // finishing in the same cycle as cs_n rising is not an abort.
        if (cs_rise_s) begin
          state_d     = IDLE;
          abort_d     = (bit_cnt_d != '0);
          bit_cnt_d   = '0;
          byte_done_d = 1'b0;
          load_s      = 1'b0;
          miso_d      = 1'b0;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = RESYNC;
        miso_d  = 1'b0;
      end
    endcase

    if (load_s) begin
      miso_d     = tx_load_s[DATA_W-1];
      tx_shift_d = tx_load_s[DATA_W-2:0];
    end else begin
      tx_shift_d = tx_shift_d;
    end

    busy_d = (state_d == ACTIVE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESYNC;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
      byte_done_q <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      abort_q     <= abort_d;
      byte_done_q <= byte_done_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = load_s;
  assign busy     = busy_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master drives the link
// and strobe monitors tally rx_valid, tx handshakes and abort pulses.
module tb_spi_slave;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       abort;

  spi_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .abort(abort)
  );

  always #2 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         rx_total = 0;
  int         hs_total = 0;
  int         ab_total = 0;
  logic [7:0] rx_log [0:63];
  logic       prev_rv  = 1'b0;
  logic       prev_tr  = 1'b0;
  logic       dbl_seen = 1'b0;
  logic       watch_miso = 1'b0;
  logic       miso_seen  = 1'b0;

  // Strobe monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_total[5:0]] = rx_data;
      rx_total = rx_total + 1;
    end
    if (tx_ready && tx_valid) hs_total = hs_total + 1;
    if (abort) ab_total = ab_total + 1;
    if ((rx_valid && prev_rv) || (tx_ready && prev_tr)) dbl_seen = 1'b1;
    if (watch_miso && miso) miso_seen = 1'b1;
    prev_rv = rx_valid;
    prev_tr = tx_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of mo out MSB first; mi collects miso at each sclk rise.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clks(HALF);
      sclk = 1'b1;
      acc  = {acc[6:0], miso};
      wait_clks(HALF);
      sclk = 1'b0;
    end
    mi = acc;
  endtask

  task automatic end_frame();
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(20);
  endtask

  int         rx_base, hs_base, ab_base;
  logic [7:0] mi, mi2;

  initial begin
    // Reset with cs_n high
    wait_clks(10);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_abort", 32'(abort), 32'h0);
    rst = 1'b0;
    wait_clks(10);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_miso", 32'(miso), 32'h0);

    // Single byte: TX A5 offered once, master sends 3C
    rx_base = rx_total; hs_base = hs_total; ab_base = ab_total;
    tx_data = 8'hA5; tx_valid = 1'b1;
    cs_n = 1'b0;
    wait_clks(6);
    tx_valid = 1'b0;
    check("b1_busy", 32'(busy), 32'h1);
    spi_bits(8'h3C, 8, mi);
    end_frame();
    check("b1_rx_count", 32'(rx_total - rx_base), 32'h1);
    check("b1_rx_data", 32'(rx_data), 32'h3C);
    check("b1_miso_byte", 32'(mi), 32'hA5);
    check("b1_handshakes", 32'(hs_total - hs_base), 32'h1);
    check("b1_abort", 32'(ab_total - ab_base), 32'h0);
    check("b1_busy_after", 32'(busy), 32'h0);

    // No TX offered: idle byte FF, master sends 00
    rx_base = rx_total; hs_base = hs_total;
    cs_n = 1'b0;
    spi_bits(8'h00, 8, mi);
    end_frame();
    check("b2_rx_count", 32'(rx_total - rx_base), 32'h1);
    check("b2_rx_data", 32'(rx_data), 32'h00);
    check("b2_miso_byte", 32'(mi), 32'hFF);
    check("b2_handshakes", 32'(hs_total - hs_base), 32'h0);

    // Two bytes in one frame
    rx_base = rx_total; hs_base = hs_total; ab_base = ab_total;
    tx_data = 8'h56; tx_valid = 1'b1;
    cs_n = 1'b0;
    wait_clks(6);
    tx_valid = 1'b0;
    spi_bits(8'h12, 8, mi);
    tx_data = 8'h78; tx_valid = 1'b1;
    wait_clks(6);
    tx_valid = 1'b0;
    spi_bits(8'h34, 8, mi2);
    end_frame();
    check("b3_rx_count", 32'(rx_total - rx_base), 32'h2);
    check("b3_rx_first", 32'(rx_log[rx_base[5:0]]), 32'h12);
    check("b3_rx_second", 32'(rx_log[6'(rx_base + 1)]), 32'h34);
    check("b3_miso_first", 32'(mi), 32'h56);
    check("b3_miso_second", 32'(mi2), 32'h78);
    check("b3_handshakes", 32'(hs_total - hs_base), 32'h2);
    check("b3_abort", 32'(ab_total - ab_base), 32'h0);

    // Early cs_n release after 5 bits, then a clean C3 frame
    rx_base = rx_total; ab_base = ab_total;
    cs_n = 1'b0;
    spi_bits(8'hFF, 5, mi);
    end_frame();
    check("ab_abort_count", 32'(ab_total - ab_base), 32'h1);
    check("ab_rx_count", 32'(rx_total - rx_base), 32'h0);
    check("ab_rx_data_hold", 32'(rx_data), 32'h34);
    rx_base = rx_total; ab_base = ab_total;
    cs_n = 1'b0;
    spi_bits(8'hC3, 8, mi);
    end_frame();
    check("ab_next_rx_count", 32'(rx_total - rx_base), 32'h1);
    check("ab_next_rx_data", 32'(rx_data), 32'hC3);
    check("ab_next_abort", 32'(ab_total - ab_base), 32'h0);

    // Reset mid-frame after 3 bits; cs_n stays low for the other 5
    rx_base = rx_total; ab_base = ab_total;
    cs_n = 1'b0;
    spi_bits(8'hE7, 3, mi);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    miso_seen = 1'b0;
    watch_miso = 1'b1;
    spi_bits(8'h3F, 5, mi);
    wait_clks(HALF);
    watch_miso = 1'b0;
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_miso_quiet", 32'(miso_seen), 32'h0);
    check("mr_rx_count", 32'(rx_total - rx_base), 32'h0);
    check("mr_rx_data", 32'(rx_data), 32'h00);
    cs_n = 1'b1;
    wait_clks(20);
    check("mr_abort", 32'(ab_total - ab_base), 32'h0);
    rx_base = rx_total;
    cs_n = 1'b0;
    spi_bits(8'h99, 8, mi);
    end_frame();
    check("mr_next_rx_count", 32'(rx_total - rx_base), 32'h1);
    check("mr_next_rx_data", 32'(rx_data), 32'h99);
    check("mr_next_miso_byte", 32'(mi), 32'hFF);

    check("strobe_single_cycle", 32'(dbl_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
